// File: rtl/param_vga_sync_gen.sv
// Parametrised VGA-style sync generator: pixel/line counters, sync decode,
// visible-area flag, line/frame start pulses and a wrapping frame counter.
module param_vga_sync_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0,
    parameter int unsigned CW        = 10
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          in_display,
    output logic [CW-1:0] count_x,
    output logic [CW-1:0] count_y,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_FIRST = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] H_SYNC_LAST  = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] V_SYNC_FIRST = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0] V_SYNC_LAST  = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [CW-1:0] H_VIS        = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_VIS        = CW'(V_DISPLAY);

    logic          x_wrap;
    logic          y_wrap;
    logic [CW-1:0] next_x;
    logic [CW-1:0] next_y;
    logic          next_hsync;
    logic          next_vsync;
    logic          next_in_display;

    // Next position and decode of that position, so levels align with the counts
    always_comb begin
        x_wrap          = (count_x == H_LAST);
        y_wrap          = x_wrap && (count_y == V_LAST);
        next_x          = x_wrap ? '0 : count_x + CW'(1);
        next_y          = count_y;
        if (x_wrap) begin
            next_y = y_wrap ? '0 : count_y + CW'(1);
        end
        next_hsync      = ((next_x >= H_SYNC_FIRST) && (next_x <= H_SYNC_LAST)) ? HSYNC_POL : ~HSYNC_POL;
        next_vsync      = ((next_y >= V_SYNC_FIRST) && (next_y <= V_SYNC_LAST)) ? VSYNC_POL : ~VSYNC_POL;
        next_in_display = (next_x < H_VIS) && (next_y < V_VIS);
    end

    // Counters, registered levels and single-clock pulses; everything holds when pix_en is low
    always_ff @(posedge clock) begin
        if (reset) begin
            count_x     <= '0;
            count_y     <= '0;
            frame_cnt   <= 8'd0;
            in_display  <= 1'b1;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                count_x     <= next_x;
                count_y     <= next_y;
                hsync       <= next_hsync;
                vsync       <= next_vsync;
                in_display  <= next_in_display;
                line_start  <= x_wrap;
                frame_start <= y_wrap;
                if (y_wrap) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_param_vga_sync_gen.sv
// Scoreboard bench for param_vga_sync_gen: three instances (reference timing,
// positive hsync with zero front porch, tiny frame for frame counter wrap).
module tb_param_vga_sync_gen;

    typedef struct {
        int hd; int hf; int hs; int hb;
        int vd; int vf; int vs; int vb;
        bit hp; bit vp;
    } cfg_t;

    typedef struct {
        int x; int y; int f;
        bit hs; bit vs; bit disp; bit ls; bit fs;
    } exp_t;

    typedef struct {
        exp_t a; exp_t b; exp_t c;
    } sb_t;

    localparam cfg_t CFG_A = '{10, 1, 5, 1, 20, 1, 2, 1, 1'b0, 1'b0};
    localparam cfg_t CFG_B = '{10, 0, 5, 1, 20, 1, 2, 1, 1'b1, 1'b0};
    localparam cfg_t CFG_C = '{2, 0, 1, 0, 2, 0, 1, 0, 1'b0, 1'b0};

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic pix_en = 1'b0;

    logic       a_hs, a_vs, a_disp, a_ls, a_fs;
    logic [4:0] a_x, a_y;
    logic [7:0] a_f;
    logic       b_hs, b_vs, b_disp, b_ls, b_fs;
    logic [4:0] b_x, b_y;
    logic [7:0] b_f;
    logic       c_hs, c_vs, c_disp, c_ls, c_fs;
    logic [4:0] c_x, c_y;
    logic [7:0] c_f;

    int checks = 0;
    int failures = 0;
    int t = 0;
    bit saw_c_wrap = 1'b0;
    sb_t sb_q[$];

    always #5 clock = ~clock;

    param_vga_sync_gen #(.H_DISPLAY(10), .H_FRONT(1), .H_SYNC(5), .H_BACK(1),
                         .V_DISPLAY(20), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                         .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(5)) u_a (
        .clock(clock), .reset(reset), .pix_en(pix_en),
        .hsync(a_hs), .vsync(a_vs), .in_display(a_disp),
        .count_x(a_x), .count_y(a_y),
        .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_f));

    param_vga_sync_gen #(.H_DISPLAY(10), .H_FRONT(0), .H_SYNC(5), .H_BACK(1),
                         .V_DISPLAY(20), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                         .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CW(5)) u_b (
        .clock(clock), .reset(reset), .pix_en(pix_en),
        .hsync(b_hs), .vsync(b_vs), .in_display(b_disp),
        .count_x(b_x), .count_y(b_y),
        .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_f));

    param_vga_sync_gen #(.H_DISPLAY(2), .H_FRONT(0), .H_SYNC(1), .H_BACK(0),
                         .V_DISPLAY(2), .V_FRONT(0), .V_SYNC(1), .V_BACK(0),
                         .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(5)) u_c (
        .clock(clock), .reset(reset), .pix_en(pix_en),
        .hsync(c_hs), .vsync(c_vs), .in_display(c_disp),
        .count_x(c_x), .count_y(c_y),
        .line_start(c_ls), .frame_start(c_fs), .frame_cnt(c_f));

    // Reference: position derived from enabled ticks since the last reset
    function automatic exp_t model(cfg_t c, int ticks, bit adv);
        exp_t e;
        int ht = c.hd + c.hf + c.hs + c.hb;
        int vt = c.vd + c.vf + c.vs + c.vb;
        e.x    = ticks % ht;
        e.y    = (ticks / ht) % vt;
        e.f    = (ticks / (ht * vt)) % 256;
        e.hs   = (e.x >= c.hd + c.hf && e.x < c.hd + c.hf + c.hs) ? c.hp : !c.hp;
        e.vs   = (e.y >= c.vd + c.vf && e.y < c.vd + c.vf + c.vs) ? c.vp : !c.vp;
        e.disp = (e.x < c.hd) && (e.y < c.vd);
        e.ls   = adv && (e.x == 0);
        e.fs   = adv && (e.x == 0) && (e.y == 0);
        return e;
    endfunction

    task automatic cmp(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    task automatic check_inst(string tag, exp_t e, int x, int y, int f,
                              bit hs, bit vs, bit disp, bit ls, bit fs);
        cmp({tag, ".count_x"}, x, e.x);
        cmp({tag, ".count_y"}, y, e.y);
        cmp({tag, ".frame_cnt"}, f, e.f);
        cmp({tag, ".hsync"}, int'(hs), int'(e.hs));
        cmp({tag, ".vsync"}, int'(vs), int'(e.vs));
        cmp({tag, ".in_display"}, int'(disp), int'(e.disp));
        cmp({tag, ".line_start"}, int'(ls), int'(e.ls));
        cmp({tag, ".frame_start"}, int'(fs), int'(e.fs));
    endtask

    // One clock of stimulus; the expected post-edge state is queued at the edge
    task automatic step(bit r, bit en);
        bit adv;
        sb_t s;
        @(negedge clock);
        reset  = r;
        pix_en = en;
        @(posedge clock);
        adv = 1'b0;
        if (r) begin
            t = 0;
        end else if (en) begin
            t++;
            adv = 1'b1;
        end
        s.a = model(CFG_A, t, adv);
        s.b = model(CFG_B, t, adv);
        s.c = model(CFG_C, t, adv);
        sb_q.push_back(s);
    endtask

    // Monitor: compare registered outputs mid-cycle against the queued expectation
    initial begin
        sb_t s;
        forever begin
            @(negedge clock);
            if (sb_q.size() > 0) begin
                s = sb_q.pop_front();
                check_inst("A", s.a, int'(a_x), int'(a_y), int'(a_f), a_hs, a_vs, a_disp, a_ls, a_fs);
                check_inst("B", s.b, int'(b_x), int'(b_y), int'(b_f), b_hs, b_vs, b_disp, b_ls, b_fs);
                check_inst("C", s.c, int'(c_x), int'(c_y), int'(c_f), c_hs, c_vs, c_disp, c_ls, c_fs);
                if (c_fs && c_f == 8'd0) saw_c_wrap = 1'b1;
            end
        end
    end

    initial begin
        int drain;
        // Reset applies regardless of pix_en
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        // Full frame of the reference instance plus a little more
        repeat (420) step(1'b0, 1'b1);
        // Alternating enable
        for (int i = 0; i < 34; i++) step(1'b0, (i % 2) == 0);
        // Random enable with sparse resets
        repeat (1500) step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0);
        // Reset with pix_en low at position (7,12) of the reference instance
        step(1'b1, 1'b1);
        repeat (7 + 12 * 17) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        // Long run so the tiny instance wraps its frame counter
        step(1'b1, 1'b1);
        repeat (2310) step(1'b0, 1'b1);
        @(negedge clock);
        pix_en = 1'b0;

        drain = 0;
        while (sb_q.size() > 0 && drain < 10) begin
            @(posedge clock);
            drain++;
        end
        cmp("scoreboard_drained", sb_q.size(), 0);
        cmp("c_frame_cnt_wrap_seen", int'(saw_c_wrap), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_vga_sync_gen.md
PARAM_VGA_SYNC_GEN -- requirements
Module: param_vga_sync_gen

Interface
REQ-001 The block SHALL have parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels, minimum 1.
REQ-004 The block SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_DISPLAY, default 480, visible lines per frame.
REQ-006 The block SHALL have parameters V_FRONT = 10, V_SYNC = 2 (minimum 1) and V_BACK = 33, giving the vertical porches and sync width in lines.
REQ-007 The block SHALL have parameter HSYNC_POL, default 0, giving the hsync active level (0 means active-low).
REQ-008 The block SHALL have parameter VSYNC_POL, default 0, giving the vsync active level.
REQ-009 The block SHALL have parameter CW, default 10, counter width, which SHALL satisfy 2^CW >= max(H_TOTAL, V_TOTAL).
REQ-010 Port: clock, input, 1 bit, sole clock; all logic on its rising edge.
REQ-011 Port: reset, input, 1 bit, synchronous, active-high.
REQ-012 Port: pix_en, input, 1 bit, pixel-rate enable; state advances only on clocks where it is high.
REQ-013 Port: hsync and vsync, outputs, 1 bit each, registered sync signals at the parametrised polarity.
REQ-014 Port: in_display, output, 1 bit, registered; high when the current position is inside the visible area.
REQ-015 Port: count_x and count_y, outputs, CW bits each, registered position.
REQ-016 Port: line_start, output, 1 bit, one-clock pulse; frame_start, output, 1 bit, one-clock pulse.
REQ-017 Port: frame_cnt, output, 8 bits, count of completed frames, wrapping.

Function
REQ-018 H_TOTAL SHALL be H_DISPLAY+H_FRONT+H_SYNC+H_BACK, and V_TOTAL SHALL be V_DISPLAY+V_FRONT+V_SYNC+V_BACK.
- Region order along each axis: display, then front porch, then sync, then back porch.
REQ-019 On a clock with pix_en high:
- count_x SHALL increment.
- When count_x == H_TOTAL-1, count_x SHALL wrap to 0 and count_y SHALL advance.
- When count_y == V_TOTAL-1 at that same wrap, count_y SHALL wrap to 0 and frame_cnt SHALL increment modulo 256.
REQ-020 With pix_en low, all counters and all level outputs SHALL hold their values, and both pulses SHALL be 0.
REQ-021 hsync, vsync and in_display SHALL be decoded from the next counter values and registered, so that they are cycle-aligned with count_x/count_y (zero skew, no extra latency).
REQ-022 hsync SHALL equal HSYNC_POL while count_x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], and ~HSYNC_POL otherwise; vsync SHALL follow the same rule on count_y with the V parameters and VSYNC_POL.
REQ-023 in_display SHALL be high iff count_x < H_DISPLAY and count_y < V_DISPLAY.
REQ-024 line_start SHALL be high for exactly the one clock in which the registered count_x becomes 0 through a wrap.
REQ-025 frame_start SHALL be high for exactly the one clock in which the registered (count_x, count_y) becomes (0,0) through a wrap; line_start SHALL also be high in that clock.
REQ-026 Porch parameters equal to 0 SHALL be legal; the sync region then abuts the display area or the wrap point directly.
REQ-027 All arithmetic SHALL be unsigned at CW bits; counters SHALL never exceed TOTAL-1.

Reset
REQ-028 When reset is high at a clock edge, regardless of pix_en, the block SHALL set:
- count_x = 0, count_y = 0, frame_cnt = 0;
- in_display = 1;
- hsync = ~HSYNC_POL, vsync = ~VSYNC_POL;
- line_start = 0, frame_start = 0.
REQ-029 Reset asserted mid-line or mid-frame SHALL take effect at the next edge, with no pulses emitted for the abandoned line or frame.
REQ-030 After reset deasserts, the first enabled clock SHALL produce count_x = 1.

Verification (params H 10/1/5/1, total 17; V 20/1/2/1, total 24; polarities 0; pix_en = 1 unless stated)
REQ-031 Reset, then 11 clocks -> count_x = 11 and hsync = 0; hsync stays 0 through count_x = 15 and is 1 at count_x = 16.
REQ-032 Run to count_x = 16, count_y = 23, then 1 clock -> counts (0,0), frame_start = 1, line_start = 1, frame_cnt = 1, in_display = 1.
REQ-033 Toggle pix_en 1/0 every clock for 34 clocks -> exactly 17 advances; one line_start; outputs frozen on every pix_en = 0 clock.
REQ-034 Assert reset at count (7,12) with pix_en = 0 -> next clock gives (0,0), frame_cnt = 0, in_display = 1, hsync = vsync = 1, no pulse.
REQ-035 HSYNC_POL = 1, H_FRONT = 0 -> hsync = 1 for count_x 10..14 and 0 elsewhere; vsync = 0 for count_y 21..22 at default polarity.
REQ-036 Run 256 frames -> frame_cnt wraps to 0 in the clock where frame_start is asserted.
